// File: rtl/sync_updown_counter_n.sv
// sync_updown_counter_n
//   Parametrised synchronous up/down counter, counting modulo MOD_VALUE
//   (0 .. MOD_VALUE-1). It has a count enable, a synchronous clear, a
//   parallel load that clamps out-of-range values, a combinational
//   terminal-count output and a registered wrap pulse.
//
//   Priority at each rising edge: clr > load > en > hold.
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MOD_VALUE  count modulus (2..2**WIDTH)
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset (Q=0, wrap=0)
//   en        in   count enable; step one position in the direction of up_dn
//   up_dn     in   direction: 1 = increment, 0 = decrement
//   clr       in   synchronous clear to 0
//   load      in   synchronous parallel load of load_val
//   load_val  in   load value; values >= MOD_VALUE load as MOD_VALUE-1
//   Q         out  current count (registered)
//   tc        out  terminal count (combinational); high the cycle before a wrap
//   wrap      out  single-cycle registered pulse, coincident with the wrapped Q
//
// Build option
//   SYNC_UPDOWN_COUNTER_SATURATE_EN : when defined, the counter holds at the
//   limits instead of wrapping. wrap stays 0 and tc flags "at limit".

module sync_updown_counter_n #(
    parameter int unsigned      WIDTH     = 8,
    parameter longint unsigned  MOD_VALUE = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    // MOD_VALUE-1 always fits in WIDTH bits, even when MOD_VALUE is 2**WIDTH.
    // Comparing against it also keeps the load clamp within WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_VALUE - 64'd1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_limit;

    // The boundary depends on the direction. It is masked by en in tc, so
    // an X on up_dn cannot propagate while the counter is idle.
    assign at_limit = up_dn ? (q_q == MAX_Q) : (q_q == '0);
    assign tc       = en & ~clr & ~load & at_limit;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
            if (!at_limit) begin
                q_d = up_dn ? q_q + 1'b1 : q_q - 1'b1;
            end
`else
            if (at_limit) begin
                q_d    = up_dn ? '0 : MAX_Q;
                wrap_d = 1'b1;
            end else begin
                q_d = up_dn ? q_q + 1'b1 : q_q - 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter_n.sv
// tb_sync_updown_counter_n
//   Directed bench for sync_updown_counter_n. It uses two instances:
//   WIDTH=4/MOD_VALUE=10 and WIDTH=8/MOD_VALUE=256. Expected values are
//   hand-computed. The saturating variant is exercised when
//   SYNC_UPDOWN_COUNTER_SATURATE_EN is defined.

module tb_sync_updown_counter_n;

    logic       clk;
    logic       reset_n;

    logic       a_en, a_up, a_clr, a_load;
    logic [3:0] a_lv, a_q;
    logic       a_tc, a_wrap;

    logic       b_en, b_up, b_clr, b_load;
    logic [7:0] b_lv, b_q;
    logic       b_tc, b_wrap;

    int n_checks;
    int n_fail;

    sync_updown_counter_n #(.WIDTH(4), .MOD_VALUE(10)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(a_en), .up_dn(a_up), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .Q(a_q), .tc(a_tc), .wrap(a_wrap)
    );

    sync_updown_counter_n #(.WIDTH(8), .MOD_VALUE(256)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(b_en), .up_dn(b_up), .clr(b_clr),
        .load(b_load), .load_val(b_lv), .Q(b_q), .tc(b_tc), .wrap(b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0] exp_up  [12];
        logic       tc_up   [12];
        logic [3:0] exp_dn  [4];
        logic       tc_dn   [4];
        logic       wr_dn   [4];

        exp_up = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        tc_up  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_dn = '{4'd1, 4'd0, 4'd9, 4'd8};
        tc_dn  = '{1'b0, 1'b0, 1'b1, 1'b0};
        wr_dn  = '{1'b0, 1'b0, 1'b1, 1'b0};

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        {a_en, a_up, a_clr, a_load} = '0;
        {b_en, b_up, b_clr, b_load} = '0;
        a_lv = '0;
        b_lv = '0;

        // Async reset is visible before any clock edge
        #3;
        check("rst_q_a",    32'(a_q), 32'd0);
        check("rst_wrap_a", 32'(a_wrap), 32'd0);
        check("rst_q_b",    32'(b_q), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_tc_a", 32'(a_tc), 32'd0);

`ifndef SYNC_UPDOWN_COUNTER_SATURATE_EN
        // Up count across the modulus: 1..9,0,1,2
        a_en = 1'b1;
        a_up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("up_tc[%0d]", i), 32'(a_tc), 32'(tc_up[i]));
            step();
            check($sformatf("up_q[%0d]", i), 32'(a_q), 32'(exp_up[i]));
            check($sformatf("up_wrap[%0d]", i), 32'(a_wrap), (exp_up[i] == 4'd0) ? 32'd1 : 32'd0);
        end

        // Down count from 2: 1,0,9,8
        a_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("dn_tc[%0d]", i), 32'(a_tc), 32'(tc_dn[i]));
            step();
            check($sformatf("dn_q[%0d]", i), 32'(a_q), 32'(exp_dn[i]));
            check($sformatf("dn_wrap[%0d]", i), 32'(a_wrap), 32'(wr_dn[i]));
        end
`else
        // Saturate: load 8, count up -> 9,9,9,9 with no wrap
        a_load = 1'b1;
        a_lv   = 4'd8;
        step();
        check("sat_load8", 32'(a_q), 32'd8);
        a_load = 1'b0;
        a_en   = 1'b1;
        a_up   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("sat_up_q[%0d]", i), 32'(a_q), 32'd9);
            check($sformatf("sat_up_tc[%0d]", i), 32'(a_tc), 32'd1);
            check($sformatf("sat_up_wrap[%0d]", i), 32'(a_wrap), 32'd0);
        end
        // Load 1, count down -> 0,0
        a_en   = 1'b0;
        a_load = 1'b1;
        a_lv   = 4'd1;
        step();
        a_load = 1'b0;
        a_en   = 1'b1;
        a_up   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("sat_dn_q[%0d]", i), 32'(a_q), 32'd0);
            check($sformatf("sat_dn_wrap[%0d]", i), 32'(a_wrap), 32'd0);
        end
`endif

        // Out-of-range load clamps to 9; load masks tc
        a_en   = 1'b0;
        a_load = 1'b1;
        a_lv   = 4'd13;
        #1;
        check("load_tc_mask", 32'(a_tc), 32'd0);
        step();
        check("load_clamp_q",    32'(a_q), 32'd9);
        check("load_clamp_wrap", 32'(a_wrap), 32'd0);

        // At Q=9 with an up-count request, load and clr must mask tc.
        // clr has priority over load.
        a_en  = 1'b1;
        a_up  = 1'b1;
        a_clr = 1'b1;
        a_lv  = 4'd5;
        #1;
        check("clr_tc_mask", 32'(a_tc), 32'd0);
        step();
        check("clr_over_load", 32'(a_q), 32'd0);
        check("clr_wrap",      32'(a_wrap), 32'd0);

        // Load has priority over the increment
        a_clr = 1'b0;
        step();
        check("load_over_en", 32'(a_q), 32'd5);

        // Hold with the enable off. X on up_dn and load_val is don't-care here.
        a_load = 1'b0;
        a_en   = 1'b0;
        a_up   = 1'bx;
        a_lv   = 4'bxxxx;
        step();
        step();
        check("hold_q",    32'(a_q), 32'd5);
        check("hold_wrap", 32'(a_wrap), 32'd0);
        check("hold_tc",   32'(a_tc), 32'd0);

        // Count up to 7, then reset asynchronously between edges
        a_up = 1'b1;
        a_lv = 4'd0;
        a_en = 1'b1;
        step();
        step();
        check("pre_rst_q", 32'(a_q), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_q",    32'(a_q), 32'd0);
        check("async_rst_wrap", 32'(a_wrap), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("resume_q1", 32'(a_q), 32'd1);
        step();
        check("resume_q2", 32'(a_q), 32'd2);
        a_en = 1'b0;

        // 8-bit full-range counter: 254 -> 255 -> 0, then turn down -> 255
        b_load = 1'b1;
        b_lv   = 8'd254;
        step();
        check("b_load254", 32'(b_q), 32'd254);
        b_load = 1'b0;
        b_en   = 1'b1;
        b_up   = 1'b1;
        #1;
        check("b_tc_254", 32'(b_tc), 32'd0);
        step();
        check("b_q_255",    32'(b_q), 32'd255);
        check("b_wrap_255", 32'(b_wrap), 32'd0);
        check("b_tc_255",   32'(b_tc), 32'd1);
`ifndef SYNC_UPDOWN_COUNTER_SATURATE_EN
        step();
        check("b_q_0",    32'(b_q), 32'd0);
        check("b_wrap_0", 32'(b_wrap), 32'd1);
        b_up = 1'b0;
        #1;
        check("b_tc_dn0", 32'(b_tc), 32'd1);
        step();
        check("b_q_dnwrap",    32'(b_q), 32'd255);
        check("b_wrap_second", 32'(b_wrap), 32'd1);
        b_en = 1'b0;
        step();
        check("b_wrap_end", 32'(b_wrap), 32'd0);
        check("b_hold_255", 32'(b_q), 32'd255);
`else
        step();
        check("b_sat_q",    32'(b_q), 32'd255);
        check("b_sat_wrap", 32'(b_wrap), 32'd0);
        b_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
